mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: response-wait limit in cycles, legal range 1..65535.
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports if_req_i input 1, if_addr_i input 32: instruction fetch request and byte address.
REQ-005 SHALL have ports if_gnt_o output 1, if_rvalid_o output 1, if_rdata_o output 32: fetch grant, response strobe and instruction word.
REQ-006 SHALL have ports d_req_i input 1, d_we_i input 1, d_size_i input 2 (00 byte, 01 half, 10 word), d_addr_i input 32, d_wdata_i input 32: data request from the MEM stage.
REQ-007 SHALL have ports d_gnt_o output 1, d_rvalid_o output 1, d_rdata_o output 32: data grant, response strobe and load data.
REQ-008 SHALL have ports mem_req_o output 1, mem_we_o output 1, mem_size_o output 2, mem_addr_o output 32, mem_wdata_o output 32: shared single-port memory request.
REQ-009 SHALL have ports mem_gnt_i input 1, mem_rvalid_i input 1, mem_rdata_i input 32: shared memory accept, response strobe and read data.
REQ-010 SHALL have ports stall_o output 1 (pipeline hold while data access pending) and err_o output 1 (timeout pulse).

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT with a 1-bit owner register (IF or D); at most one transaction outstanding.
REQ-012 SHALL in IDLE, with any request present, select the owner, latch its address/we/size/wdata, and enter ISSUE next cycle; IF requests force mem_we_o=0 and mem_size_o=10.
REQ-013 SHALL by default give d_req_i fixed priority over if_req_i when both are asserted in the same IDLE cycle.
REQ-014 SHALL drive mem_req_o and the mem_* request fields from registers, high only in ISSUE; first mem_req_o cycle is one cycle after the request is seen in IDLE.
REQ-015 SHALL hold mem_req_o and fields stable in ISSUE until mem_gnt_i=1, then move to WAIT.
REQ-016 SHALL assert owner's gnt_o combinationally for exactly the cycle ISSUE and mem_gnt_i coincide; the other gnt_o stays 0.
REQ-017 SHALL in WAIT, on mem_rvalid_i=1, pulse owner's rvalid_o for that cycle with rdata_o = mem_rdata_i and return to IDLE.
REQ-018 SHALL treat mem_rvalid_i=1 in the same cycle as mem_gnt_i in ISSUE as an immediate response (rvalid_o pulse, next state IDLE).
REQ-019 SHALL ignore mem_rvalid_i in IDLE; non-owner rvalid_o and rdata_o are 0.
REQ-020 SHALL count WAIT cycles in a 16-bit counter cleared on entry; on reaching TIMEOUT_CYCLES without mem_rvalid_i, pulse err_o and owner's rvalid_o with rdata_o=0 for one cycle and return to IDLE.
REQ-021 SHALL assert stall_o when d_req_i=1 or owner=D with state not IDLE, except in the cycle d_rvalid_o=1.
REQ-022 SHALL keep requester inputs sampled only in IDLE; changes while another transaction is in flight have no effect.

Reset
REQ-023 SHALL on rst_i=1 asynchronously force state IDLE, owner IF, counter 0, all registered outputs 0; any in-flight transaction is dropped.
REQ-024 SHALL after reset release ignore stale mem_rvalid_i (state IDLE) and arbitrate normally from the first clock edge.

Configuration
REQ-025 SHALL, when ARB_ROUND_ROBIN_EN is defined, replace fixed priority with round-robin: on simultaneous requests, grant the requester not served by the last completed transaction (last-owner register reset to D, so IF wins first).
REQ-026 SHALL, when ARB_ROUND_ROBIN_EN is undefined, use fixed data priority per REQ-013 with no last-owner register.

Verification
REQ-027 Fetch only: if_req_i=1, if_addr_i=0x100, mem_gnt_i next cycle, mem_rvalid_i one cycle later with 0x00500093 -> mem_addr_o=0x100 at cycle 1, if_gnt_o at cycle 1, if_rvalid_o and if_rdata_o=0x00500093 at cycle 2.
REQ-028 Collision: if_req_i and d_req_i (store, addr 0x2000, wdata 0xDEADBEEF, size 10) same cycle -> data issued first with mem_we_o=1, stall_o high until d_rvalid_o, fetch issued in the following IDLE.
REQ-029 Round-robin (macro defined): two back-to-back collisions -> grant order IF, D, IF, D.
REQ-030 Timeout with TIMEOUT_CYCLES=4: grant given, no mem_rvalid_i -> err_o and owner rvalid_o pulse with rdata 0 on fourth WAIT cycle, state IDLE.
REQ-031 Reset mid-WAIT then late mem_rvalid_i=1 -> all outputs 0, no rvalid_o pulse, next request serviced normally.
REQ-032 Zero-latency memory: mem_gnt_i and mem_rvalid_i both high in first ISSUE cycle -> gnt_o and rvalid_o same cycle, new request issued two cycles later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to replace fixed data priority with round-robin arbitration.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_size_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic        OWN_IF       = 1'b0;
  localparam logic        OWN_D        = 1'b1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic [15:0] wait_cnt;
  logic        d_prio;
  logic        sel_d;
  logic        start;
  logic        timeout;
  logic        respond;
  logic        gnt;
  logic [31:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who completed last; reset to D so a first collision goes to IF.
  logic last_owner;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_owner <= OWN_D;
    end else if (respond) begin
      last_owner <= owner;
    end
  end

  assign d_prio = (last_owner == OWN_IF);
`else
  assign d_prio = 1'b1;
`endif

  assign sel_d     = d_req_i & (~if_req_i | d_prio);
  assign start     = (state == IDLE) & (if_req_i | d_req_i);
  assign timeout   = (state == WAIT) & ~mem_rvalid_i & (wait_cnt == TIMEOUT_LAST);
  assign respond   = ((state == WAIT) & (mem_rvalid_i | timeout))
                   | ((state == ISSUE) & mem_gnt_i & mem_rvalid_i);
  assign gnt       = (state == ISSUE) & mem_gnt_i;
  assign resp_data = timeout ? 32'd0 : mem_rdata_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (mem_gnt_i) state_nxt = mem_rvalid_i ? IDLE : WAIT;
      WAIT:    if (respond) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      wait_cnt    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_size_o  <= 2'b00;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state     <= state_nxt;
      mem_req_o <= (state_nxt == ISSUE);
      if (state != WAIT) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      // Requester inputs are captured only here, so in-flight changes are ignored.
      if (start) begin
        owner       <= sel_d ? OWN_D : OWN_IF;
        mem_we_o    <= sel_d & d_we_i;
        mem_size_o  <= sel_d ? d_size_i : 2'b10;
        mem_addr_o  <= sel_d ? d_addr_i : if_addr_i;
        mem_wdata_o <= sel_d ? d_wdata_i : 32'd0;
      end
    end
  end

  assign if_gnt_o    = gnt & (owner == OWN_IF);
  assign d_gnt_o     = gnt & (owner == OWN_D);
  assign if_rvalid_o = respond & (owner == OWN_IF);
  assign d_rvalid_o  = respond & (owner == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? resp_data : 32'd0;
  assign d_rdata_o   = d_rvalid_o ? resp_data : 32'd0;
  assign err_o       = timeout;
  assign stall_o     = (d_req_i | ((owner == OWN_D) & (state != IDLE))) & ~d_rvalid_o;

endmodule
`default_nettype wire
